// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives one DSP48A1 slice as an N-sample multiply-accumulate.
// Operand pairs arrive on a valid/ready stream. The slice A/B/OPMODE/CE pins are
// driven so that P accumulates a[i]*b[i]. After the last pair the slice pipeline
// is drained, and the 48-bit result is offered on a valid/ready output.
//
// Optional build macro MAC_SUB_EN adds a sub_mode input, which is latched with
// start. When it is latched high, every opmode is issued with bit 7 set, so the
// slice computes P = Z - X and the result is the negated sum of products.
//
// Expected slice setup: A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1,
// B_INPUT="DIRECT", CARRYINSEL="OPMODE5".
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start with a non-zero len; slice clock-enable low
// ST_RUN   | accepting operand pairs; HOLD opmode issued on input bubbles
// ST_DRAIN | last pair accepted; flushing A1/B1 -> M -> P for DRAIN_CYC cycles
// ST_DONE  | result presented; slice frozen until the result is taken

module dsp_mac_sequencer #(
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
`ifdef MAC_SUB_EN
   input  logic             sub_mode,
`endif
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [17:0]      a_in,
   input  logic [17:0]      b_in,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ce,
   input  logic [47:0]      dsp_p,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [47:0]      res_data
);

   // Opmode fields: bit 7 selects subtract, bits [3:2] are Z, bits [1:0] are X.
   localparam logic [6:0] OP_FIRST = 7'h01;   // X=M, Z=0
   localparam logic [6:0] OP_ACC   = 7'h09;   // X=M, Z=P
   localparam logic [6:0] OP_HOLD  = 7'h08;   // X=0, Z=P

   localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [DRN_W-1:0] drain_q, drain_d;
   logic [7:0]       opmode_q, opmode_d;
   logic             res_valid_q, res_valid_d;
   logic [47:0]      res_data_q, res_data_d;
   logic             sub_bit;

`ifdef MAC_SUB_EN
   logic sub_q, sub_d;

   // Subtract selection, latched with the start command
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sub_q <= 1'b0;
      else     sub_q <= sub_d;
   end

   // The new mode takes effect only when a command is accepted in IDLE
   always_comb begin
      sub_d = sub_q;
      if (state_q == ST_IDLE && start && len != '0) sub_d = sub_mode;
   end

   assign sub_bit = sub_q;
`else
   assign sub_bit = 1'b0;
`endif

   // Registers for the control state, counters, opmode and result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         first_q     <= 1'b0;
         drain_q     <= '0;
         opmode_q    <= {1'b0, OP_HOLD};
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
         drain_q     <= drain_d;
         opmode_q    <= opmode_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   // Next-state logic. The opmode defaults to HOLD on every edge that does not
   // carry an operand handshake, so bubble products in A1/B1/M are never added.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
      drain_d     = drain_q;
      opmode_d    = {sub_bit, OP_HOLD};
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;

      case (state_q)
         ST_IDLE: begin
            if (start && len != '0) begin
               state_d = ST_RUN;
               len_d   = len;
               cnt_d   = '0;
               first_d = 1'b1;
            end
         end

         ST_RUN: begin
            if (in_valid) begin
               opmode_d = first_q ? {sub_bit, OP_FIRST} : {sub_bit, OP_ACC};
               first_d  = 1'b0;
               cnt_d    = cnt_q + CNT_W'(1);
               // len_q is non-zero here, so len_q-1 never underflows
               if (cnt_q == len_q - CNT_W'(1)) begin
                  state_d = ST_DRAIN;
                  drain_d = '0;
               end
            end
         end

         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               res_data_d  = dsp_p;
               res_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               drain_d = drain_q + DRN_W'(1);
            end
         end

         ST_DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Status, handshake and slice-control outputs decoded from the state register
   always_comb begin
      busy     = (state_q != ST_IDLE);
      in_ready = (state_q == ST_RUN);
      dsp_ce   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   end

   // Operands pass straight through; the slice A1/B1 registers do the capture
   assign dsp_a      = a_in;
   assign dsp_b      = b_in;
   assign dsp_opmode = opmode_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed testbench for dsp_mac_sequencer. A small behavioural DSP48A1 model
// (A1/B1 -> M -> P, with a registered OPMODE) closes the loop on dsp_p.
module tb_dsp_mac_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] len;
   logic        busy;
   logic        in_valid;
   logic        in_ready;
   logic [17:0] a_in, b_in;
   logic [17:0] dsp_a, dsp_b;
   logic [7:0]  dsp_opmode;
   logic        dsp_ce;
   logic [47:0] dsp_p;
   logic        res_valid;
   logic        res_ready;
   logic [47:0] res_data;
`ifdef MAC_SUB_EN
   logic        sub_mode;
`endif

   int pass_cnt = 0;
   int chk_cnt  = 0;

   dsp_mac_sequencer #(.CNT_W(16), .DRAIN_CYC(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
`ifdef MAC_SUB_EN
      .sub_mode   (sub_mode),
`endif
      .busy       (busy),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .dsp_a      (dsp_a),
      .dsp_b      (dsp_b),
      .dsp_opmode (dsp_opmode),
      .dsp_ce     (dsp_ce),
      .dsp_p      (dsp_p),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slice model: unsigned 18x18 multiply, MREG, OPMODEREG and PREG
   logic [17:0] s_a1 = '0, s_b1 = '0;
   logic [35:0] s_m  = '0;
   logic [7:0]  s_op = 8'h08;
   logic [47:0] s_p  = '0;
   logic [47:0] s_x, s_z;
   assign s_x   = (s_op[1:0] == 2'b01) ? {12'b0, s_m} : 48'b0;
   assign s_z   = (s_op[3:2] == 2'b10) ? s_p : 48'b0;
   assign dsp_p = s_p;

   always @(posedge clk) begin
      if (dsp_ce) begin
         s_a1 <= dsp_a;
         s_b1 <= dsp_b;
         s_m  <= 36'(s_a1) * 36'(s_b1);
         s_op <= dsp_opmode;
         s_p  <= s_op[7] ? (s_z - s_x) : (s_z + s_x);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (dsp_ce !== 1'b0) $display("FAIL reset_dsp_ce: got %0b want 0", dsp_ce); else pass_cnt++;
      chk_cnt++; if (dsp_opmode !== 8'h08) $display("FAIL reset_opmode: got %h want 08", dsp_opmode); else pass_cnt++;
      chk_cnt++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'd0) $display("FAIL reset_res_data: got %h want 0", res_data); else pass_cnt++;
      rst = 1'b0;
      tick();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %0b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_full_rate();
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0; len = 16'd0;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL full_busy: got %0b want 1", busy); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b1) $display("FAIL full_in_ready: got %0b want 1", in_ready); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         a_in = 18'(i + 1); b_in = 18'd2; in_valid = 1'b1;
         tick();
         chk_cnt++;
         if (dsp_opmode !== ((i == 0) ? 8'h01 : 8'h09))
            $display("FAIL full_opmode[%0d]: got %h want %h", i, dsp_opmode, (i == 0) ? 8'h01 : 8'h09);
         else pass_cnt++;
      end
      in_valid = 1'b0; a_in = '0; b_in = '0;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL full_drain_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (dsp_ce !== 1'b1) $display("FAIL full_drain_ce: got %0b want 1", dsp_ce); else pass_cnt++;
      tick();
      chk_cnt++; if (dsp_opmode !== 8'h08) $display("FAIL full_drain_opmode: got %h want 08", dsp_opmode); else pass_cnt++;
      tick();
      chk_cnt++; if (res_valid !== 1'b0) $display("FAIL full_early_valid: got %0b want 0", res_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL full_res_valid: got %0b want 1", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'd20) $display("FAIL full_res_data: got %0d want 20", res_data); else pass_cnt++;
      chk_cnt++; if (dsp_ce !== 1'b0) $display("FAIL full_done_ce: got %0b want 0", dsp_ce); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk_cnt++; if (res_valid !== 1'b0) $display("FAIL full_accept_valid: got %0b want 0", res_valid); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL full_accept_busy: got %0b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_bubbles();
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_in = 18'(i + 1); b_in = 18'd2; in_valid = 1'b1;
         tick();
         chk_cnt++;
         if (dsp_opmode !== ((i == 0) ? 8'h01 : 8'h09))
            $display("FAIL bub_opmode[%0d]: got %h want %h", i, dsp_opmode, (i == 0) ? 8'h01 : 8'h09);
         else pass_cnt++;
         if (i < 3) begin
            in_valid = 1'b0; a_in = 18'h3FFFF; b_in = 18'h3FFFF;
            tick();
            chk_cnt++; if (dsp_opmode !== 8'h08) $display("FAIL bub_hold[%0d]: got %h want 08", i, dsp_opmode); else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bub_in_ready[%0d]: got %0b want 1", i, in_ready); else pass_cnt++;
         end
      end
      in_valid = 1'b0; a_in = '0; b_in = '0;
      repeat (3) tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL bub_res_valid: got %0b want 1", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'd20) $display("FAIL bub_res_data: got %0d want 20", res_data); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_max_operands();
      start = 1'b1; len = 16'd1;
      tick();
      start = 1'b0;
      a_in = 18'h3FFFF; b_in = 18'h3FFFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; a_in = '0; b_in = '0;
      chk_cnt++; if (dsp_opmode !== 8'h01) $display("FAIL max_opmode: got %h want 01", dsp_opmode); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL max_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      repeat (2) tick();
      chk_cnt++; if (res_valid !== 1'b0) $display("FAIL max_early_valid: got %0b want 0", res_valid); else pass_cnt++;
      tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL max_res_valid: got %0b want 1", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'h000F_FFF8_0001) $display("FAIL max_res_data: got %h want 000ffff80001", res_data); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_done_hold();
      start = 1'b1; len = 16'd1;
      tick();
      start = 1'b0;
      a_in = 18'd7; b_in = 18'd3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      for (int k = 0; k < 10; k++) begin
         if (k == 3) begin start = 1'b1; len = 16'd5; end
         tick();
         start = 1'b0;
         chk_cnt++; if (res_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %0b want 1", k, res_valid); else pass_cnt++;
         chk_cnt++; if (res_data !== 48'd21) $display("FAIL hold_data[%0d]: got %0d want 21", k, res_data); else pass_cnt++;
      end
      chk_cnt++; if (busy !== 1'b1) $display("FAIL hold_busy: got %0b want 1", busy); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL hold_accept_busy: got %0b want 0", busy); else pass_cnt++;
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      a_in = 18'd5; b_in = 18'd1; in_valid = 1'b1;
      tick();
      a_in = 18'd6;
      tick();
      in_valid = 1'b0;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL next_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      repeat (3) tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL next_res_valid: got %0b want 1", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'd11) $display("FAIL next_res_data: got %0d want 11", res_data); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic seen_valid;
      start = 1'b1; len = 16'd4;
      tick();
      start = 1'b0;
      a_in = 18'd1; b_in = 18'd2; in_valid = 1'b1;
      tick();
      a_in = 18'd2;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rstmid_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      chk_cnt++; if (dsp_ce !== 1'b0) $display("FAIL rstmid_ce: got %0b want 0", dsp_ce); else pass_cnt++;
      chk_cnt++; if (dsp_opmode !== 8'h08) $display("FAIL rstmid_opmode: got %h want 08", dsp_opmode); else pass_cnt++;
      tick();
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (res_valid !== 1'b0) seen_valid = 1'b1;
      end
      chk_cnt++; if (seen_valid !== 1'b0) $display("FAIL rstmid_no_result: got %0b want 0", seen_valid); else pass_cnt++;
      start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0;
      a_in = 18'd3; b_in = 18'd3; in_valid = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk_cnt++; if (res_valid !== 1'b1) $display("FAIL rstmid_res_valid: got %0b want 1", res_valid); else pass_cnt++;
      chk_cnt++; if (res_data !== 48'd18) $display("FAIL rstmid_res_data: got %0d want 18", res_data); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_len_zero();
      logic bad;
      start = 1'b1; len = 16'd0;
      tick();
      start = 1'b0;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy); else pass_cnt++;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL zero_in_ready: got %0b want 0", in_ready); else pass_cnt++;
      bad = 1'b0;
      in_valid = 1'b1; res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (res_valid !== 1'b0 || busy !== 1'b0 || dsp_ce !== 1'b0) bad = 1'b1;
      end
      in_valid = 1'b0; res_ready = 1'b0;
      chk_cnt++; if (bad !== 1'b0) $display("FAIL zero_quiet: got %0b want 0", bad); else pass_cnt++;
   endtask

`ifdef MAC_SUB_EN
   task automatic test_sub();
      sub_mode = 1'b1; start = 1'b1; len = 16'd2;
      tick();
      start = 1'b0; sub_mode = 1'b0;
      a_in = 18'd2; b_in = 18'd3; in_valid = 1'b1;
      tick();
      chk_cnt++; if (dsp_opmode !== 8'h81) $display("FAIL sub_first: got %h want 81", dsp_opmode); else pass_cnt++;
      a_in = 18'd1; b_in = 18'd1;
      tick();
      in_valid = 1'b0;
      chk_cnt++; if (dsp_opmode !== 8'h89) $display("FAIL sub_acc: got %h want 89", dsp_opmode); else pass_cnt++;
      repeat (3) tick();
      chk_cnt++; if (res_data !== 48'hFFFF_FFFF_FFF9) $display("FAIL sub_res_data: got %h want fffffffffff9", res_data); else pass_cnt++;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      a_in = '0; b_in = '0; res_ready = 1'b0;
`ifdef MAC_SUB_EN
      sub_mode = 1'b0;
`endif
      test_reset();
      test_full_rate();
      test_bubbles();
      test_max_operands();
      test_done_hold();
      test_reset_mid();
      test_len_zero();
`ifdef MAC_SUB_EN
      test_sub();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
